// File: rtl/t_toggle_receiver.sv
// t_toggle_receiver: receiving end of a toggle-handshake link driven by a
// sender T flip-flop. Synchronises req_t, captures data_in on each toggle,
// offers it on a valid/ready port and toggles ack_t back on consumption.
// Ports:
//   clk      - rising-edge clock
//   clr      - asynchronous active-high clear of all state
//   req_t    - toggle request from the sender (either edge = one word)
//   data_in  - sender data, stable until the matching ack_t toggle
//   ack_t    - toggle acknowledge back to the sender
//   dout     - captured word
//   valid    - dout holds an unconsumed word
//   ready    - consumer accepts dout when valid && ready
//   overrun  - sticky flag: a toggle arrived while a word was still held
//   evt_cnt  - completed transfers, wraps modulo 2^CNT_W
module t_toggle_receiver #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             req_t,
   input  logic [WIDTH-1:0] data_in,
   output logic             ack_t,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   input  logic             ready,
   output logic             overrun,
   output logic [CNT_W-1:0] evt_cnt
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   req_s;
   logic                   req_last;
   logic                   tgl;

   assign req_s = sync[SYNC_STAGES-1];
   assign tgl   = req_s ^ req_last;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync     <= '0;
         req_last <= 1'b0;
         state    <= IDLE;
         ack_t    <= 1'b0;
         dout     <= '0;
         valid    <= 1'b0;
         overrun  <= 1'b0;
         evt_cnt  <= '0;
      end else begin
         sync     <= {sync[SYNC_STAGES-2:0], req_t};
         // Always consume the toggle so a dropped one is never re-detected.
         req_last <= req_s;
         unique case (state)
            IDLE: begin
               if (tgl) begin
                  dout  <= data_in;
                  valid <= 1'b1;
                  state <= HOLD;
               end
            end
            HOLD: begin
               // A toggle while holding is dropped; dout is kept.
               if (tgl) begin
                  overrun <= 1'b1;
               end
               if (ready) begin
                  valid   <= 1'b0;
                  ack_t   <= ~ack_t;
                  evt_cnt <= evt_cnt + CNT_W'(1);
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/t_toggle_receiver.md
# t_toggle_receiver

Receiving end of the toggle-handshake link whose sender is a T flip-flop.
- Sender side: the T flip-flop's q output drives `req_t`, and the sender holds `data_in` stable. Each toggle of `req_t` (either edge) signals one new word.
- This block synchronises `req_t` and detects each toggle, captures `data_in`, and presents the word on a valid/ready port to the downstream consumer.
- On consumption it toggles `ack_t` back to the sender. It also counts completed transfers and flags protocol overruns.

## Interface
Parameters:
- WIDTH, 8, data word width
- SYNC_STAGES, 2, synchroniser depth on `req_t` (legal range ≥ 2)
- CNT_W, 8, width of the transfer counter

Ports:
- clk  input  1  clock, rising-edge active
- clr  input  1  reset: asynchronous, active-high; clears all state immediately
- req_t  input  1  toggle request from the sender's T flip-flop
- data_in  input  WIDTH  sender data, stable from the `req_t` toggle until the matching `ack_t` toggle
- ack_t  output  1  toggle acknowledge back to the sender
- dout  output  WIDTH  captured word
- valid  output  1  `dout` holds an unconsumed word
- ready  input  1  consumer accepts `dout` at an edge where valid && ready
- overrun  output  1  sticky protocol-violation flag
- evt_cnt  output  CNT_W  number of completed transfers, wraps modulo 2^CNT_W

## Operation
- Reset values while clr=1: ack_t=0, dout=0, valid=0, overrun=0, evt_cnt=0. All synchroniser flops and req_last are also 0; this matches the sender T flip-flop's reset value of q=0.
- Synchroniser: a SYNC_STAGES-deep flop chain on req_t; its last stage is req_s.
- req_last register: holds the last req_s value that has been processed.
- Toggle detected (tgl) when req_s != req_last. On every edge, req_last <= req_s.
- State machine, two states:
  - IDLE (valid=0):
    - tgl → dout <= data_in, valid <= 1, go to HOLD.
    - Otherwise stay in IDLE.
  - HOLD (valid=1):
    - valid && ready → valid <= 0, ack_t <= ~ack_t, evt_cnt <= evt_cnt+1, go to IDLE.
    - Otherwise hold dout and valid unchanged.
- Overrun: tgl detected in HOLD.
  - Sets overrun=1. The flag stays set until clr.
  - The new toggle is dropped: dout is not overwritten and no extra ack_t is issued.
  - req_last still updates, so the dropped toggle is never re-detected.
  - An acceptance (valid && ready) at the same edge still completes normally.
- tgl and acceptance cannot coincide legally, because the sender only toggles after it sees ack_t. If they do coincide, the overrun rule applies.
- evt_cnt wraps from 2^CNT_W−1 to 0 and does not saturate.
- ready while valid=0 is ignored.
- clr asserted mid-transfer: immediately returns to IDLE with the reset values above. A held word is lost and no ack_t is sent.

## Timing
- Notation: E0 is the first rising edge at which the toggled req_t is sampled.
- req_s changes at edge E0+SYNC_STAGES−1.
- valid rises and dout loads at edge E0+SYNC_STAGES; with the default depth this is 2 edges after E0.
- Acceptance at edge A: at A, valid falls, ack_t toggles and evt_cnt increments, all in the same edge.
- Minimum spacing between accepted words is SYNC_STAGES+1 cycles after the sender sees ack_t; this block adds no extra bubble.
- Consumer side: dout and valid are registered outputs with no combinational path from ready. ack_t is registered.
- clr is asynchronous on assertion. Release is synchronous to clk, and the release timing is owned by the integrating level.

## Test plan
- Reset: hold clr=1 for 2 cycles with req_t=1 and data_in=8'hFF → all outputs 0 throughout. After release with req_t still 1 → exactly one transfer is detected.
- Single transfer:
  - Stimulus: data_in=8'hA5, toggle req_t 0→1, ready=0.
  - Response: valid rises 2 edges after the sampling edge, dout=8'hA5.
  - Then ready=1 for one cycle → valid=0, ack_t=1, evt_cnt=1.
- Both edges: run transfers with data 8'h01 (req_t 0→1) then 8'h02 (req_t 1→0), each acked → dout values 8'h01 then 8'h02, ack_t returns to 0, evt_cnt=2.
- Overrun:
  - Stimulus: with valid=1 holding 8'h11, toggle req_t again with data_in=8'h22.
  - Response: overrun=1, dout stays 8'h11. After ready, evt_cnt increments by 1 only and the overrun flag persists.
- Wrap: CNT_W=8, 256 handshaked transfers → evt_cnt returns to 0. ack_t parity equals req_t at every idle point.
- Reset mid-transfer: assert clr while valid=1 and ready=0 → valid, dout, ack_t and evt_cnt are 0 immediately, without waiting for a clock edge. After release, a new transfer completes normally.
